// File: rtl/tl_phase_scheduler_pkg.sv
// Shared definitions for the intersection scheduler: light colours, phase
// encodings, the registered display record and the BCD helpers.
package tl_phase_scheduler_pkg;

  localparam logic [2:0] GREEN  = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] RED    = 3'b001;

  localparam logic [1:0] PH_HG = 2'd0;
  localparam logic [1:0] PH_HY = 2'd1;
  localparam logic [1:0] PH_CG = 2'd2;
  localparam logic [1:0] PH_CY = 2'd3;

  typedef struct packed {
    logic [2:0] color_h;
    logic [2:0] color_cr;
    logic [7:0] count_h;
    logic [7:0] count_cr;
  } disp_t;

  // Values above 99 clamp so the two-digit display never shows garbage.
  function automatic logic [7:0] bin2bcd8(input logic [7:0] v);
    logic [7:0] t;
    t = (v > 8'd99) ? 8'd99 : v;
    return {4'(t / 8'd10), 4'(t % 8'd10)};
  endfunction

  function automatic logic [7:0] sat_add99(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > 9'd99) ? 8'd99 : s[7:0];
  endfunction

  // The waiting road shows its own time plus the other road's yellow.
  function automatic disp_t disp_of(input logic [1:0] st, input logic [7:0] rem,
                                    input logic [7:0] t_yellow);
    disp_t d;
    d.color_h  = RED;
    d.color_cr = RED;
    d.count_h  = bin2bcd8(rem);
    d.count_cr = bin2bcd8(rem);
    case (st)
      PH_HG: begin
        d.color_h  = GREEN;
        d.count_cr = bin2bcd8(sat_add99(rem, t_yellow));
      end
      PH_HY: d.color_h = YELLOW;
      PH_CG: begin
        d.color_cr = GREEN;
        d.count_h  = bin2bcd8(sat_add99(rem, t_yellow));
      end
      default: d.color_cr = YELLOW;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// One-second prescaler: emits a registered single-cycle pulse every TICK_DIV
// clocks, in the cycle after the counter reaches its last value.
module tl_tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_pre;
  logic          r_tick;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_pre == LAST);
      r_pre  <= (r_pre == LAST) ? '0 : r_pre + PW'(1);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/tl_phase_scheduler.sv
// Highway / country-road light scheduler: one state register drives both roads,
// so conflicting greens are impossible by construction.
module tl_phase_scheduler
  import tl_phase_scheduler_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter logic [7:0]  T_GREEN    = 8'd30,
  parameter logic [7:0]  T_YELLOW   = 8'd5,
  parameter logic [7:0]  T_CR_GREEN = 8'd20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car_detected,
  output logic [2:0] color_h,
  output logic [2:0] color_cr,
  output logic [7:0] count_h,
  output logic [7:0] count_cr,
  output logic [1:0] phase,
  output logic       tick
);

  logic       w_tick;
  logic       r_car_meta, r_car_s;
  logic [1:0] r_state, w_state_nxt;
  logic [7:0] r_rem, w_rem_nxt;
  disp_t      r_disp;

  tl_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  // NOTE: next-state logic assigns defaults first so no path leaves a signal
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    if (w_tick) begin
      if (r_state == PH_CG && !r_car_s) begin
        w_state_nxt = PH_CY;
        w_rem_nxt   = T_YELLOW;
      end else if (r_rem > 8'd1) begin
        w_rem_nxt = r_rem - 8'd1;
      end else begin
        case (r_state)
          PH_HG: begin
            // Minimum green served; without a car, park at 00 until one shows.
            if (r_car_s) begin
              w_state_nxt = PH_HY;
              w_rem_nxt   = T_YELLOW;
            end else begin
              w_rem_nxt = 8'd0;
            end
          end
          PH_HY: begin
            w_state_nxt = PH_CG;
            w_rem_nxt   = T_CR_GREEN;
          end
          PH_CG: begin
            w_state_nxt = PH_CY;
            w_rem_nxt   = T_YELLOW;
          end
          default: begin
            w_state_nxt = PH_HG;
            w_rem_nxt   = T_GREEN;
          end
        endcase
      end
    end
  end

  // Display registers load from the next state so counts never lag the timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_car_meta <= 1'b0;
      r_car_s    <= 1'b0;
      r_state    <= PH_HG;
      r_rem      <= T_GREEN;
      r_disp     <= disp_of(PH_HG, T_GREEN, T_YELLOW);
    end else begin
      r_car_meta <= car_detected;
      r_car_s    <= r_car_meta;
      r_state    <= w_state_nxt;
      r_rem      <= w_rem_nxt;
      r_disp     <= disp_of(w_state_nxt, w_rem_nxt, T_YELLOW);
    end
  end

  assign color_h  = r_disp.color_h;
  assign color_cr = r_disp.color_cr;
  assign count_h  = r_disp.count_h;
  assign count_cr = r_disp.count_cr;
  assign phase    = r_state;
  assign tick     = w_tick;

endmodule

// File: tb/tb_tl_phase_scheduler.sv
// Directed bench for tl_phase_scheduler: a vector table for the main light
// sequence plus hand sequences for sensor timing, reset abort and overrides.
module tb_tl_phase_scheduler;

  localparam int TD = 4;
  localparam logic [2:0] G = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b001;

  typedef struct {
    bit         do_reset;
    bit         car;
    logic [1:0] phase;
    logic [2:0] ch;
    logic [2:0] ccr;
    logic [7:0] cnt_h;
    logic [7:0] cnt_cr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       car;
  logic [2:0] color_h, color_cr, color_h2, color_cr2;
  logic [7:0] count_h, count_cr, count_h2, count_cr2;
  logic [1:0] phase, phase2;
  logic       tick, tick2;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  tl_phase_scheduler #(
    .TICK_DIV(TD), .T_GREEN(8'd3), .T_YELLOW(8'd2), .T_CR_GREEN(8'd4)
  ) dut (
    .clk(clk), .rst(rst), .car_detected(car),
    .color_h(color_h), .color_cr(color_cr),
    .count_h(count_h), .count_cr(count_cr),
    .phase(phase), .tick(tick)
  );

  tl_phase_scheduler #(
    .TICK_DIV(TD), .T_GREEN(8'd60), .T_YELLOW(8'd39), .T_CR_GREEN(8'd4)
  ) dut_ovr (
    .clk(clk), .rst(rst), .car_detected(car),
    .color_h(color_h2), .color_cr(color_cr2),
    .count_h(count_h2), .count_cr(count_cr2),
    .phase(phase2), .tick(tick2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    check({tag, " phase"},    32'(phase),    32'(v.phase));
    check({tag, " color_h"},  32'(color_h),  32'(v.ch));
    check({tag, " color_cr"}, 32'(color_cr), 32'(v.ccr));
    check({tag, " count_h"},  32'(count_h),  32'(v.cnt_h));
    check({tag, " count_cr"}, 32'(count_cr), 32'(v.cnt_cr));
  endtask

  // Holds rst across exactly one rising edge; outputs are sampled just after it.
  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Returns the number of edges until tick is seen high (bounded).
  task automatic edges_to_tick(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (tick !== 1'b1 && n < 3 * TD);
  endtask

  // Advances to just after the edge that consumes the next tick.
  task automatic wait_update();
    int n;
    edges_to_tick(n);
    if (tick !== 1'b1) check("tick_timeout", 32'(tick), 32'd1);
    @(posedge clk); #1;
  endtask

  // Conflicting greens/yellows must never appear, in either instance.
  always @(negedge clk) begin
    check("safety", 32'(color_h != R && color_cr != R), 32'd0);
    check("safety_ovr", 32'(color_h2 != R && color_cr2 != R), 32'd0);
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1;
    car = 1'b0;

    // Car absent: minimum green runs down and parks at 00/02.
    vecs.push_back('{1, 0, 2'd0, G, R, 8'h03, 8'h05});
    vecs.push_back('{0, 0, 2'd0, G, R, 8'h02, 8'h04});
    vecs.push_back('{0, 0, 2'd0, G, R, 8'h01, 8'h03});
    vecs.push_back('{0, 0, 2'd0, G, R, 8'h00, 8'h02});
    vecs.push_back('{0, 0, 2'd0, G, R, 8'h00, 8'h02});
    // Car present from reset: one full cycle HG -> HY -> CG -> CY -> HG.
    vecs.push_back('{1, 1, 2'd0, G, R, 8'h03, 8'h05});
    vecs.push_back('{0, 1, 2'd0, G, R, 8'h02, 8'h04});
    vecs.push_back('{0, 1, 2'd0, G, R, 8'h01, 8'h03});
    vecs.push_back('{0, 1, 2'd1, Y, R, 8'h02, 8'h02});
    vecs.push_back('{0, 1, 2'd1, Y, R, 8'h01, 8'h01});
    vecs.push_back('{0, 1, 2'd2, R, G, 8'h06, 8'h04});
    vecs.push_back('{0, 1, 2'd2, R, G, 8'h05, 8'h03});
    vecs.push_back('{0, 1, 2'd2, R, G, 8'h04, 8'h02});
    vecs.push_back('{0, 1, 2'd2, R, G, 8'h03, 8'h01});
    vecs.push_back('{0, 1, 2'd3, R, Y, 8'h02, 8'h02});
    vecs.push_back('{0, 1, 2'd3, R, Y, 8'h01, 8'h01});
    vecs.push_back('{0, 1, 2'd0, G, R, 8'h03, 8'h05});

    for (int i = 0; i < vecs.size(); i++) begin
      car = vecs[i].car;
      if (vecs[i].do_reset) begin
        apply_reset();
        check($sformatf("vec%0d tick", i), 32'(tick), 32'd0);
      end else begin
        wait_update();
      end
      check_vec($sformatf("vec%0d", i), vecs[i]);
      if (i == 0) begin
        check("ovr count_h", 32'(count_h2), 32'h60);
        check("ovr count_cr", 32'(count_cr2), 32'h99);
        check("ovr color_h", 32'(color_h2), 32'(G));
      end
    end

    // Tick period once running.
    edges_to_tick(n);
    edges_to_tick(n);
    check("tick_period", 32'(n), 32'(TD));

    // Early end of country green when the car leaves.
    car = 1'b1;
    apply_reset();
    for (int k = 0; k < 6; k++) wait_update();
    check_vec("cg_rem3", '{0, 1, 2'd2, R, G, 8'h05, 8'h03});
    car = 1'b0;
    wait_update();
    check_vec("early_end", '{0, 0, 2'd3, R, Y, 8'h02, 8'h02});

    // Reset in the middle of highway yellow: straight back to HG, prescaler cleared.
    car = 1'b1;
    apply_reset();
    for (int k = 0; k < 3; k++) wait_update();
    check("in_hy phase", 32'(phase), 32'd1);
    @(posedge clk); #1;
    apply_reset();
    check_vec("rst_mid_hy", '{1, 1, 2'd0, G, R, 8'h03, 8'h05});
    edges_to_tick(n);
    check("rst_pre_cleared", 32'(n), 32'(TD));
    @(posedge clk); #1;
    check_vec("after_rst_hy", '{0, 1, 2'd0, G, R, 8'h02, 8'h04});

    // One-cycle car pulse before expiry changes nothing.
    car = 1'b0;
    apply_reset();
    wait_update();
    car = 1'b1;
    @(posedge clk); #1;
    car = 1'b0;
    wait_update();
    check_vec("pulse_early a", '{0, 0, 2'd0, G, R, 8'h01, 8'h03});
    wait_update();
    check_vec("pulse_early b", '{0, 0, 2'd0, G, R, 8'h00, 8'h02});

    // Parked at 00: a pulse whose synchronised copy misses the tick cycle is ignored.
    car = 1'b1;
    @(posedge clk); #1;
    car = 1'b0;
    wait_update();
    check_vec("pulse_miss", '{0, 0, 2'd0, G, R, 8'h00, 8'h02});

    // Pulse timed so car_s is high exactly in the tick cycle -> yellow.
    @(posedge clk); #1;
    car = 1'b1;
    @(posedge clk); #1;
    car = 1'b0;
    wait_update();
    check_vec("pulse_on_tick", '{0, 0, 2'd1, Y, R, 8'h02, 8'h02});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
